// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
//
// Contents:
//   SZ_BYTE/SZ_HALF/SZ_WORD  request size encodings (2'b11 behaves as word)
//   state_t                  responder FSM states IDLE/WAIT/ACCESS/RESP
//   WCNT_W                   wait-state counter width
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int WCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_lane_unit.sv
// rtl/dmem_lane_unit.sv - byte/half/word lane merge and load extension
//
// Ports:
//   word        in  32  current contents of the addressed RAM word
//   addr_lo     in  2   byte offset within the word
//   size        in  2   SZ_BYTE / SZ_HALF / word (2'b10 and 2'b11)
//   is_unsigned in  1   zero-extend loads when 1, sign-extend when 0
//   wdata       in  32  right-aligned store data
//   merged      out 32  word with the store lane replaced
//   load_ext    out 32  selected lane extended to 32 bits
//
// Half accesses use only addr_lo[1]; word accesses ignore addr_lo entirely.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] load_ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'h00;
    case (addr_lo)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    merged   = word;
    load_ext = word;
    case (size)
      SZ_BYTE: begin
        load_ext = {{24{~is_unsigned & lane_b[7]}}, lane_b};
        case (addr_lo)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        load_ext = {{16{~is_unsigned & lane_h[15]}}, lane_h};
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      default: begin
        merged   = wdata;
        load_ext = word;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with handshake and wait states
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready request handshake; ready only while IDLE
//   req_we/req_addr/req_wdata/req_size/req_unsigned  request fields
//   resp_valid/resp_ready response handshake
//   resp_rdata          extended load data, 0 for stores
//   resp_err            misaligned access flag
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN. When defined, misaligned
// half/word accesses skip the RAM write and respond with rdata=0, err=1.
// When undefined, offending low address bits are ignored and err stays 0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int AW = IW + 2;

  state_t              state;
  logic [WCNT_W-1:0]   wait_cnt;
  logic                l_we;
  logic [AW-1:0]       l_addr;
  logic [31:0]         l_wdata;
  logic [1:0]          l_size;
  logic                l_unsigned;

  logic [31:0]         mem [DEPTH_WORDS];
  logic [31:0]         cur_word;
  logic [31:0]         merged_word;
  logic [31:0]         load_data;
  logic                misaligned;

  // Address bits above the array are dropped, so accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:AW];

  assign req_ready = (state == IDLE);
  assign cur_word  = mem[l_addr[AW-1:2]];

  dmem_lane_unit u_lane (
    .word        (cur_word),
    .addr_lo     (l_addr[1:0]),
    .size        (l_size),
    .is_unsigned (l_unsigned),
    .wdata       (l_wdata),
    .merged      (merged_word),
    .load_ext    (load_data)
  );

`ifdef DMEM_ALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if (l_size == SZ_HALF)
      misaligned = l_addr[0];
    else if (l_size != SZ_BYTE)
      misaligned = (l_addr[1:0] != 2'b00);
  end
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      l_we       <= 1'b0;
      l_addr     <= '0;
      l_wdata    <= '0;
      l_size     <= SZ_BYTE;
      l_unsigned <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            l_we       <= req_we;
            l_addr     <= req_addr[AW-1:0];
            l_wdata    <= req_wdata;
            l_size     <= req_size;
            l_unsigned <= req_unsigned;
            if (WAIT_CYCLES > 0) begin
              state    <= WAIT;
              wait_cnt <= WCNT_W'(WAIT_CYCLES - 1);
            end else begin
              state    <= ACCESS;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) state <= ACCESS;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        ACCESS: begin
          resp_valid <= 1'b1;
          resp_err   <= misaligned;
          resp_rdata <= (l_we || misaligned) ? 32'h0 : load_data;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM is not reset; a write commits only on the ACCESS edge, so an
  // asynchronous reset before that edge leaves the word untouched.
  always_ff @(posedge clk) begin
    if (state == ACCESS && l_we && !misaligned)
      mem[l_addr[AW-1:2]] <= merged_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam int DEPTH  = 1024;
  localparam int WAITC  = 2;
  localparam int NBYTES = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  int errors = 0;
  int checks = 0;

  // Byte-addressed reference memory.
  logic [7:0] ref_mem [NBYTES];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] sz, input bit uns,
                                output logic [31:0] rd, output logic er);
    int n;
    int a;
    logic [31:0] v;
    n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    a  = int'(addr % NBYTES);
    rd = 32'h0;
    er = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    if ((a % n) != 0) begin
      er = 1'b1;
      return;
    end
`endif
    a = a - (a % n);
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[a + i] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + i];
      if (!uns && n < 4 && v[8*n-1])
        for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      rd = v;
    end
  endfunction

  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] sz, input bit uns, input int hold,
                     output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic        exp_er;
    logic [31:0] held;
    int          lat;
    model(we, addr, wdata, sz, uns, exp_rd, exp_er);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = sz;
    req_unsigned = uns;
    check("req_ready_idle", req_ready, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, WAITC + 1);
    check("resp_rdata", resp_rdata, exp_rd);
    check("resp_err", resp_err, exp_er);
    held = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", resp_valid, 32'd1);
      check("hold_rdata", resp_rdata, held);
      check("hold_req_ready", req_ready, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("resp_valid_drop", resp_valid, 32'd0);
    check("req_ready_back", req_ready, 32'd1);
    rd = held;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] r;
    logic [31:0] a;
    logic [1:0]  sz;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'b10; req_unsigned = 1'b0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_req_ready", req_ready, 32'd1);
    check("reset_resp_valid", resp_valid, 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    check("reset_resp_err", resp_err, 32'd0);

    // Clear the working region so every later load has a known value.
    for (int i = 0; i < 32; i++) txn(1'b1, 32'(4 * i), 32'h0, 2'b10, 1'b0, 0, rd);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0, rd);
    check("store_word_rdata0", rd, 32'h0);
    txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd);
    check("load_word", rd, 32'hDEADBEEF);

    txn(1'b1, 32'h11, 32'h00000080, 2'b00, 1'b0, 0, rd);
    txn(1'b0, 32'h11, 32'h0, 2'b00, 1'b0, 0, rd);
    check("load_byte_signed", rd, 32'hFFFFFF80);
    txn(1'b0, 32'h11, 32'h0, 2'b00, 1'b1, 0, rd);
    check("load_byte_unsigned", rd, 32'h00000080);
    txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 5, rd);
    check("load_word_merged", rd, 32'hDEAD80EF);

    txn(1'b0, 32'h10 + 4 * DEPTH, 32'h0, 2'b10, 1'b0, 0, rd);
    check("load_wrap", rd, 32'hDEAD80EF);

    txn(1'b1, 32'h13, 32'h0000A5A5, 2'b01, 1'b0, 0, rd);
    txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd);
`ifdef DMEM_ALIGN_CHECK_EN
    check("misaligned_half_no_write", rd, 32'hDEAD80EF);
`else
    check("misaligned_half_upper", rd, 32'hA5A580EF);
`endif

    // Reset during WAIT of a store: nothing committed, outputs cleared at once.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    req_size = 2'b10; req_unsigned = 1'b0;
    check("abort_req_ready", req_ready, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_req_ready_rst", req_ready, 32'd1);
    check("abort_resp_valid", resp_valid, 32'd0);
    check("abort_resp_rdata", resp_rdata, 32'd0);
    check("abort_resp_err", resp_err, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    txn(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0, rd);
    check("abort_not_committed", rd, 32'h0);

    for (int i = 0; i < 60; i++) begin
      r  = $urandom;
      a  = (r & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
      sz = 2'($urandom_range(0, 3));
      txn(1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)),
          $urandom_range(0, 2), rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the load/store port driven by the single-cycle core datapath.
- The core supplies address = ALU result and write data = rs2; this block returns read data for MemtoReg.
- Adds a valid/ready request and response handshake, configurable wait states, byte/half/word lanes and load sign/zero extension.
- Sits between the core's memory port and a word-organised RAM array held inside this block.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of 2.
- WAIT_CYCLES, 2, wait states inserted between acceptance and access (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  misaligned access (see Optional Feature).

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. Reset forces state IDLE, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
- RAM contents are not reset.
- States: IDLE, WAIT, ACCESS, RESP.
- req_ready=1 only in IDLE; it is decoded combinationally from state.
- IDLE: on req_valid&req_ready at edge E, latch we/addr/wdata/size/unsigned.
  - If WAIT_CYCLES>0: go to WAIT with counter=WAIT_CYCLES-1.
  - If WAIT_CYCLES=0: go to ACCESS.
- WAIT: decrement the counter each edge; at counter=0, go to ACCESS.
- ACCESS (exactly 1 cycle):
  - Store: byte-lane merge into word addr[log2(DEPTH_WORDS)+1:2]. Byte lane = addr[1:0]; half lane = addr[1].
  - Load: extract the lane, then extend to 32 bits.
  - Go to RESP.
- Latency: resp_valid rises after edge E+WAIT_CYCLES+1.
- RESP: hold resp_valid, resp_rdata and resp_err stable until resp_valid&resp_ready, then go to IDLE on that edge.
  - The next request can be accepted no earlier than the following cycle; there is no back-to-back overlap.
- Address bits above log2(DEPTH_WORDS)+1 are ignored, so accesses wrap modulo the array size.
- req_* inputs are ignored outside IDLE; only the latched copies are used.
- Reset mid-operation: the transaction is aborted.
  - A store not yet through its ACCESS edge is never committed.
  - A committed store persists.
- A store response carries resp_rdata=0.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- Defined: a misaligned access (half with addr[0]=1, or word with addr[1:0]!=0) performs no RAM write and returns resp_rdata=0, resp_err=1. Latency is unchanged.
- Undefined: offending low address bits are forced to zero (half ignores addr[0], word ignores addr[1:0]). resp_err is tied 0.

Decomposition:
- Package dmem_pkg:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - State enum IDLE/WAIT/ACCESS/RESP.
  - Wait-counter width constant (4).
- One combinational sub-module, dmem_lane_unit:
  - Inputs: stored word, addr[1:0], size, unsigned, wdata.
  - Outputs: merged write word and extended load data.
  - Reused by the FSM for both directions.

Test Plan:
- Reset then idle, WAIT_CYCLES=2 → req_ready=1, resp_valid=0, resp_rdata=0.
- Store word 0xDEADBEEF @0x10, then load word @0x10 → resp_rdata=0xDEADBEEF; resp_valid rises 3 edges after each accept.
- Store byte 0x80 @0x11, then load byte signed @0x11 → 0xFFFFFF80. Load unsigned → 0x00000080. Load word @0x10 → 0xDEAD80EF.
- Hold resp_ready=0 for 5 cycles during a load response → resp_valid and data stay stable and req_ready stays 0; after the handshake, IDLE resumes.
- Load word @0x10+4*DEPTH_WORDS → same data as @0x10 (wrap).
- With DMEM_ALIGN_CHECK_EN, store half @0x13 → resp_err=1, RAM unchanged. Without the macro → the half is written at lane addr[1]=1 and resp_err=0.
- Assert rst during WAIT of a store 0x12345678 @0x20 → the store is not committed and outputs return to reset values immediately.
